mult_err_sweeper: RTL and testbench
===================================

Name: mult_err_sweeper

Overview:
- Synthesizable, parametrised error-characterisation engine for approximate multipliers.
- Sweeps every operand pair (a, b) in [0, 2^W-1]^2 into a pipelined DUT multiplier with fixed latency.
- Compares each DUT result against the exact product and accumulates error metrics: sum of absolute error distance (for MED/MRED post-processing), maximum error distance, and mismatch count.
- Sits beside mult_wrapper on FPGA/emulation builds; replaces software sweeps for the approximate-multiplier family.

Parameters:
- W, 8, operand width in bits (product width 2W).
- LAT, 3, DUT latency in cycles from operand drive to valid dut_y (0 = combinational DUT).
- ACC_W, 4*W, width of the sum_ed accumulator (sized so it never overflows).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored while busy.
- busy  out  1  high from the cycle after start until the sweep completes.
- done  out  1  high after a completed sweep; held until the next start or rst.
- op_a  out  W  operand A driven to the DUT.
- op_b  out  W  operand B driven to the DUT.
- dut_y  in  2W  DUT product, valid LAT cycles after op_a/op_b are driven.
- sum_ed  out  ACC_W  sum over all pairs of |dut_y - a*b|.
- max_ed  out  2W  maximum |dut_y - a*b| over the sweep.
- err_cnt  out  2W+1  number of pairs where dut_y != a*b.
- pair_cnt  out  2W+1  number of pairs scored so far.

Behaviour:
- Reset:
  - State IDLE.
  - op_a, op_b, sum_ed, max_ed, err_cnt and pair_cnt are all 0.
  - busy = 0, done = 0.
  - The operand delay line is cleared.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE --start--> SWEEP. On this transition, clear all metrics, done, and both operand counters.
  - SWEEP issues one pair per cycle.
    - Order: a is the outer loop, b the inner loop; b wraps from 2^W-1 to 0 and increments a.
    - After issuing pair (2^W-1, 2^W-1): go to DRAIN, or to DONE if LAT = 0.
  - DRAIN lasts exactly LAT cycles, then goes to DONE.
  - DONE --start--> SWEEP, with the same clear as from IDLE.
- Scoring:
  - Each issued pair enters a LAT-deep valid/operand shift register.
  - On the cycle the delayed valid is high:
    - exact = a_d*b_d, computed at 2W bits.
    - ed = |dut_y - exact|, computed at 2W+1 bits signed, then magnitude.
    - sum_ed += ed.
    - max_ed = max(max_ed, ed).
    - err_cnt increments if ed != 0.
    - pair_cnt increments.
- Total sweep time is 2^(2W) + LAT cycles from the first SWEEP cycle. On completion, pair_cnt = 2^(2W).
- busy is high in SWEEP and DRAIN only. done rises on entry to DONE.
- op_a and op_b hold their last value (all ones) in DRAIN and DONE.
- Zero operands are scored like any other pair (no special casing).
- start asserted while busy: ignored, with no effect on counters.
- rst mid-sweep: immediate return to the reset state; in-flight pairs are discarded.
- Metrics are stable and readable in DONE.

Optional Feature:
- Macro: MULT_ERR_WCE_CAPTURE_EN.
- Defined:
  - Adds outputs wce_a [W] and wce_b [W], both reset to 0 and cleared on start.
  - They record the operands of the first pair achieving a strictly greater ed than the current max_ed.
  - A tie does not update them.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package mult_err_pkg:
  - sweep_state_t enum {IDLE, SWEEP, DRAIN, DONE}.
  - Default constants for W, LAT and ACC_W.
- Sub-module err_delay_line: LAT-stage shift register of {valid, a, b}.
  - Parametrised on W and LAT.
  - LAT = 0 is a pass-through.
  - Asynchronous active-high reset clears all stages.

Test Plan:
- W=4, LAT=3, DUT = exact registered multiplier, one start pulse:
  - done after 256+3 cycles.
  - sum_ed = 0, max_ed = 0, err_cnt = 0, pair_cnt = 256.
- W=4, LAT=0, DUT forces bit 0 of y to 0:
  - err_cnt = 64 (pairs with odd product: a and b both odd, 8x8).
  - max_ed = 1, sum_ed = 64.
- W=4, LAT=2, DUT returns 0 for every pair:
  - sum_ed = 14400 (= (sum 0..15)^2).
  - max_ed = 225, err_cnt = 225.
  - With MULT_ERR_WCE_CAPTURE_EN: wce_a = 15, wce_b = 15.
- Second start asserted 50 cycles into a sweep:
  - Ignored; done arrives at the original cycle 256+LAT.
  - Metrics match a single clean sweep.
- rst asserted mid-SWEEP (pair 100), then start:
  - All outputs read 0 during reset.
  - The new sweep yields the full, uncorrupted results.
- Back-to-back: start pulsed in DONE:
  - Metrics clear on the transition to SWEEP and a fresh sweep completes identically.

Source files
------------

// File: rtl/mult_err_pkg.sv
// Shared types and default sizing for the approximate-multiplier error sweeper.
package mult_err_pkg;

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} sweep_state_t;

   localparam int DEF_W     = 8;
   localparam int DEF_LAT   = 3;
   localparam int DEF_ACC_W = 4 * DEF_W;

endpackage

// File: rtl/err_delay_line.sv
// LAT-stage shift register carrying {valid, a, b} alongside the DUT pipeline.
// LAT = 0 degenerates to a wire so a combinational DUT is scored in the issue cycle.
module err_delay_line #(
   parameter int W   = 8,
   parameter int LAT = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         vld_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         vld_o,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o
);

   if (LAT == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign vld_o = vld_i;
      assign a_o   = a_i;
      assign b_o   = b_i;
   end else begin : g_pipe
      logic         vld_q [LAT];
      logic [W-1:0] a_q   [LAT];
      logic [W-1:0] b_q   [LAT];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < LAT; i++) begin
               vld_q[i] <= 1'b0;
               a_q[i]   <= '0;
               b_q[i]   <= '0;
            end
         end else begin
            vld_q[0] <= vld_i;
            a_q[0]   <= a_i;
            b_q[0]   <= b_i;
            for (int i = 1; i < LAT; i++) begin
               vld_q[i] <= vld_q[i-1];
               a_q[i]   <= a_q[i-1];
               b_q[i]   <= b_q[i-1];
            end
         end
      end

      assign vld_o = vld_q[LAT-1];
      assign a_o   = a_q[LAT-1];
      assign b_o   = b_q[LAT-1];
   end

endmodule

// File: rtl/mult_err_sweeper.sv
// Exhaustive operand sweep of a LAT-cycle multiplier, accumulating error metrics.
// Define MULT_ERR_WCE_CAPTURE_EN to add wce_a/wce_b worst-case operand capture.
module mult_err_sweeper
   import mult_err_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int LAT   = DEF_LAT,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [W-1:0]     op_a,
   output logic [W-1:0]     op_b,
   input  logic [2*W-1:0]   dut_y,
   output logic [ACC_W-1:0] sum_ed,
   output logic [2*W-1:0]   max_ed,
   output logic [2*W:0]     err_cnt,
   output logic [2*W:0]     pair_cnt
`ifdef MULT_ERR_WCE_CAPTURE_EN
   ,
   output logic [W-1:0]     wce_a,
   output logic [W-1:0]     wce_b
`endif
);

   localparam int PW   = 2 * W;
   localparam int CW   = 2 * W + 1;
   localparam int DC_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int DL   = (LAT > 0) ? LAT - 1 : 0;
   localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DL);
   localparam logic [W-1:0]    OP_MAX     = '1;

   function automatic logic [PW-1:0] abs_ed(input logic [PW-1:0] y, input logic [PW-1:0] x);
      logic signed [PW:0] diff;
      diff = $signed({1'b0, y}) - $signed({1'b0, x});
      abs_ed = diff[PW] ? PW'(-diff) : diff[PW-1:0];
   endfunction

   sweep_state_t    state_q;
   logic [W-1:0]    a_q, b_q;
   logic            busy_q, done_q;
   logic [DC_W-1:0] drain_q;

   logic start_acc;
   logic last_pair;
   assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
   assign last_pair = (a_q == OP_MAX) && (b_q == OP_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         drain_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= SWEEP;
                  a_q     <= '0;
                  b_q     <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  drain_q <= '0;
               end
            end
            SWEEP: begin
               if (last_pair) begin
                  if (LAT == 0) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= DRAIN;
                  end
               end else begin
                  b_q <= b_q + W'(1);
                  if (b_q == OP_MAX) a_q <= a_q + W'(1);
               end
            end
            DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q + DC_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic         dl_vld;
   logic [W-1:0] dl_a, dl_b;

   err_delay_line #(.W(W), .LAT(LAT)) u_dl (
      .clk   (clk),
      .rst   (rst),
      .vld_i (state_q == SWEEP),
      .a_i   (a_q),
      .b_i   (b_q),
      .vld_o (dl_vld),
      .a_o   (dl_a),
      .b_o   (dl_b)
   );

   // Score stage: the delayed operands line up with the DUT result this cycle.
   logic [PW-1:0]    exact, ed;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [PW-1:0]    max_q, max_d;
   logic [CW-1:0]    err_q, err_d, pair_q, pair_d;

   assign exact = PW'(dl_a) * PW'(dl_b);
   assign ed    = abs_ed(dut_y, exact);

   always_comb begin
      sum_d  = sum_q;
      max_d  = max_q;
      err_d  = err_q;
      pair_d = pair_q;
      if (start_acc) begin
         sum_d  = '0;
         max_d  = '0;
         err_d  = '0;
         pair_d = '0;
      end else if (dl_vld) begin
         sum_d  = sum_q + ACC_W'(ed);
         if (ed > max_q) max_d = ed;
         if (ed != '0) err_d = err_q + CW'(1);
         pair_d = pair_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= '0;
         max_q  <= '0;
         err_q  <= '0;
         pair_q <= '0;
      end else begin
         sum_q  <= sum_d;
         max_q  <= max_d;
         err_q  <= err_d;
         pair_q <= pair_d;
      end
   end

`ifdef MULT_ERR_WCE_CAPTURE_EN
   logic [W-1:0] wa_q, wa_d, wb_q, wb_d;

   // Only a strictly larger error moves the capture; ties keep the first pair.
   always_comb begin
      wa_d = wa_q;
      wb_d = wb_q;
      if (start_acc) begin
         wa_d = '0;
         wb_d = '0;
      end else if (dl_vld && (ed > max_q)) begin
         wa_d = dl_a;
         wb_d = dl_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wa_q <= '0;
         wb_q <= '0;
      end else begin
         wa_q <= wa_d;
         wb_q <= wb_d;
      end
   end

   assign wce_a = wa_q;
   assign wce_b = wb_q;
`endif

   assign busy     = busy_q;
   assign done     = done_q;
   assign op_a     = a_q;
   assign op_b     = b_q;
   assign sum_ed   = sum_q;
   assign max_ed   = max_q;
   assign err_cnt  = err_q;
   assign pair_cnt = pair_q;

endmodule

// File: tb/tb_mult_err_sweeper.sv
// Bench for mult_err_sweeper: three W=4 instances (LAT 3, 0, 2) each driving a behavioural multiplier.
module tb_mult_err_sweeper;

   localparam int W = 4;
   localparam int N = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_s [3];
   logic       busy_s  [3];
   logic       done_s  [3];
   logic [3:0] opa_s   [3];
   logic [3:0] opb_s   [3];
   logic [7:0] y_s     [3];
   logic [15:0] sum_s  [3];
   logic [7:0] max_s   [3];
   logic [8:0] err_s   [3];
   logic [8:0] pair_s  [3];
`ifdef MULT_ERR_WCE_CAPTURE_EN
   logic [3:0] wa_s    [3];
   logic [3:0] wb_s    [3];
`endif

   int lat_tab [3] = '{3, 0, 2};
   int checks = 0;
   int fails  = 0;

   int         mode;
   logic [7:0] ytab [256];

   // Multiplier under characterisation: exact, LSB-dropped, all-zero, or a random table.
   function automatic logic [7:0] mul_ut(input int md, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = 8'(a) * 8'(b);
      case (md)
         0:       return p;
         1:       return p & 8'hFE;
         2:       return 8'h00;
         default: return ytab[{a, b}];
      endcase
   endfunction

   logic [7:0] pipe3 [3];
   logic [7:0] pipe2 [2];
   always @(posedge clk) begin
      pipe3[0] <= mul_ut(mode, opa_s[0], opb_s[0]);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
      pipe2[0] <= mul_ut(mode, opa_s[2], opb_s[2]);
      pipe2[1] <= pipe2[0];
   end
   assign y_s[0] = pipe3[2];
   assign y_s[1] = mul_ut(mode, opa_s[1], opb_s[1]);
   assign y_s[2] = pipe2[1];

   mult_err_sweeper #(.W(W), .LAT(3), .ACC_W(16)) u_l3 (
`ifdef MULT_ERR_WCE_CAPTURE_EN
      .wce_a(wa_s[0]), .wce_b(wb_s[0]),
`endif
      .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
      .op_a(opa_s[0]), .op_b(opb_s[0]), .dut_y(y_s[0]), .sum_ed(sum_s[0]),
      .max_ed(max_s[0]), .err_cnt(err_s[0]), .pair_cnt(pair_s[0]));

   mult_err_sweeper #(.W(W), .LAT(0), .ACC_W(16)) u_l0 (
`ifdef MULT_ERR_WCE_CAPTURE_EN
      .wce_a(wa_s[1]), .wce_b(wb_s[1]),
`endif
      .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
      .op_a(opa_s[1]), .op_b(opb_s[1]), .dut_y(y_s[1]), .sum_ed(sum_s[1]),
      .max_ed(max_s[1]), .err_cnt(err_s[1]), .pair_cnt(pair_s[1]));

   mult_err_sweeper #(.W(W), .LAT(2), .ACC_W(16)) u_l2 (
`ifdef MULT_ERR_WCE_CAPTURE_EN
      .wce_a(wa_s[2]), .wce_b(wb_s[2]),
`endif
      .clk(clk), .rst(rst), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
      .op_a(opa_s[2]), .op_b(opb_s[2]), .dut_y(y_s[2]), .sum_ed(sum_s[2]),
      .max_ed(max_s[2]), .err_cnt(err_s[2]), .pair_cnt(pair_s[2]));

   // Reference metrics over the whole operand square for the current multiplier mode.
   longint exp_sum;
   int     exp_max, exp_err, exp_wa, exp_wb;

   task automatic ref_model();
      exp_sum = 0; exp_max = 0; exp_err = 0; exp_wa = 0; exp_wb = 0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            int d;
            d = int'(mul_ut(mode, 4'(a), 4'(b))) - a * b;
            if (d < 0) d = -d;
            exp_sum += d;
            if (d != 0) exp_err++;
            if (d > exp_max) begin exp_max = d; exp_wa = a; exp_wb = b; end
         end
      end
   endtask

   task automatic fill_random_table();
      for (int i = 0; i < 256; i++)
         ytab[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'((i / 16) * (i % 16));
   endtask

   // Pulse start on instance k and follow the sweep; optionally re-pulse start or assert rst at pair n.
   task automatic do_sweep(input int k, input int extra_at, input int rst_at, output int cyc);
      int n, op_bad, expn;
      op_bad = 0;
      @(negedge clk); start_s[k] = 1'b1;
      @(posedge clk); #1; start_s[k] = 1'b0;
      if ({busy_s[k], done_s[k], sum_s[k], max_s[k], err_s[k], pair_s[k]} !== {1'b1, 43'd0}) begin
         fails++;
         $display("FAIL start_clear[%0d]: busy=%b done=%b sum=%0d max=%0d err=%0d pair=%0d, need busy=1 rest 0",
                  k, busy_s[k], done_s[k], sum_s[k], max_s[k], err_s[k], pair_s[k]);
      end
      checks++;
      n = 0;
      while (done_s[k] !== 1'b1 && n < 2000) begin
         expn = (n < N) ? n : N - 1;
         if ({opa_s[k], opb_s[k]} !== 8'(expn) || busy_s[k] !== 1'b1) op_bad++;
         if (n == extra_at) start_s[k] = 1'b1;
         if (n == rst_at) begin rst = 1'b1; break; end
         @(posedge clk); #1;
         start_s[k] = 1'b0;
         n++;
      end
      cyc = n;
      if (rst_at < 0) begin
         if (op_bad !== 0 || busy_s[k] !== 1'b0) begin
            fails++;
            $display("FAIL op_seq[%0d]: %0d bad operand/busy cycles, busy at end=%b, need 0 and 0", k, op_bad, busy_s[k]);
         end
         checks++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         if ({busy_s[k], done_s[k], opa_s[k], opb_s[k], sum_s[k], max_s[k], err_s[k], pair_s[k]} !== 52'd0) begin
            fails++;
            $display("FAIL reset_state[%0d]: busy=%b done=%b a=%0d b=%0d sum=%0d max=%0d err=%0d pair=%0d, need all 0",
                     k, busy_s[k], done_s[k], opa_s[k], opb_s[k], sum_s[k], max_s[k], err_s[k], pair_s[k]);
         end
         checks++;
`ifdef MULT_ERR_WCE_CAPTURE_EN
         if ({wa_s[k], wb_s[k]} !== 8'd0) begin
            fails++; $display("FAIL reset_wce[%0d]: got %0d,%0d need 0,0", k, wa_s[k], wb_s[k]);
         end
         checks++;
`endif
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_exact_lat3();
      int cyc;
      mode = 0;
      do_sweep(0, -1, -1, cyc);
      if (cyc !== N + 3) begin fails++; $display("FAIL exact_latency: got %0d need %0d", cyc, N + 3); end
      checks++;
      if ({sum_s[0], max_s[0], err_s[0]} !== 32'd0 || pair_s[0] !== 9'd256) begin
         fails++;
         $display("FAIL exact_metrics: sum=%0d max=%0d err=%0d pair=%0d need 0 0 0 256", sum_s[0], max_s[0], err_s[0], pair_s[0]);
      end
      checks++;
      repeat (5) @(posedge clk);
      #1;
      if (done_s[0] !== 1'b1 || pair_s[0] !== 9'd256 || {opa_s[0], opb_s[0]} !== 8'hFF) begin
         fails++;
         $display("FAIL done_hold: done=%b pair=%0d ops=%0d,%0d need 1 256 15,15", done_s[0], pair_s[0], opa_s[0], opb_s[0]);
      end
      checks++;
   endtask

   task automatic test_lsb_lat0();
      int cyc;
      mode = 1;
      do_sweep(1, -1, -1, cyc);
      if (cyc !== N) begin fails++; $display("FAIL lsb_latency: got %0d need %0d", cyc, N); end
      checks++;
      if (err_s[1] !== 9'd64 || max_s[1] !== 8'd1 || sum_s[1] !== 16'd64 || pair_s[1] !== 9'd256) begin
         fails++;
         $display("FAIL lsb_metrics: sum=%0d max=%0d err=%0d pair=%0d need 64 1 64 256", sum_s[1], max_s[1], err_s[1], pair_s[1]);
      end
      checks++;
   endtask

   task automatic test_zero_lat2();
      int cyc;
      mode = 2;
      do_sweep(2, -1, -1, cyc);
      if (cyc !== N + 2) begin fails++; $display("FAIL zero_latency: got %0d need %0d", cyc, N + 2); end
      checks++;
      if (sum_s[2] !== 16'd14400 || max_s[2] !== 8'd225 || err_s[2] !== 9'd225 || pair_s[2] !== 9'd256) begin
         fails++;
         $display("FAIL zero_metrics: sum=%0d max=%0d err=%0d pair=%0d need 14400 225 225 256", sum_s[2], max_s[2], err_s[2], pair_s[2]);
      end
      checks++;
`ifdef MULT_ERR_WCE_CAPTURE_EN
      if (wa_s[2] !== 4'd15 || wb_s[2] !== 4'd15) begin
         fails++; $display("FAIL zero_wce: got %0d,%0d need 15,15", wa_s[2], wb_s[2]);
      end
      checks++;
`endif
   endtask

   task automatic test_random_error();
      int cyc;
      mode = 3;
      for (int rep = 0; rep < 2; rep++) begin
         fill_random_table();
         ref_model();
         for (int k = 0; k < 3; k++) begin
            do_sweep(k, -1, -1, cyc);
            if (cyc !== N + lat_tab[k] || sum_s[k] !== 16'(exp_sum) || max_s[k] !== 8'(exp_max) ||
                err_s[k] !== 9'(exp_err) || pair_s[k] !== 9'd256) begin
               fails++;
               $display("FAIL random_metrics[%0d]: cyc=%0d sum=%0d max=%0d err=%0d pair=%0d need %0d %0d %0d %0d 256",
                        k, cyc, sum_s[k], max_s[k], err_s[k], pair_s[k], N + lat_tab[k], exp_sum, exp_max, exp_err);
            end
            checks++;
`ifdef MULT_ERR_WCE_CAPTURE_EN
            if (wa_s[k] !== 4'(exp_wa) || wb_s[k] !== 4'(exp_wb)) begin
               fails++; $display("FAIL random_wce[%0d]: got %0d,%0d need %0d,%0d", k, wa_s[k], wb_s[k], exp_wa, exp_wb);
            end
            checks++;
`endif
         end
      end
   endtask

   task automatic test_start_while_busy();
      int cyc;
      mode = 3;
      fill_random_table();
      ref_model();
      do_sweep(0, 50, -1, cyc);
      if (cyc !== N + 3 || sum_s[0] !== 16'(exp_sum) || max_s[0] !== 8'(exp_max) ||
          err_s[0] !== 9'(exp_err) || pair_s[0] !== 9'd256) begin
         fails++;
         $display("FAIL busy_start: cyc=%0d sum=%0d max=%0d err=%0d pair=%0d need %0d %0d %0d %0d 256",
                  cyc, sum_s[0], max_s[0], err_s[0], pair_s[0], N + 3, exp_sum, exp_max, exp_err);
      end
      checks++;
   endtask

   task automatic test_reset_mid_sweep();
      int cyc;
      mode = 3;
      fill_random_table();
      ref_model();
      do_sweep(0, -1, 100, cyc);
      #1;
      if ({busy_s[0], done_s[0], opa_s[0], opb_s[0], sum_s[0], max_s[0], err_s[0], pair_s[0]} !== 52'd0) begin
         fails++;
         $display("FAIL mid_reset: busy=%b done=%b a=%0d b=%0d sum=%0d max=%0d err=%0d pair=%0d, need all 0",
                  busy_s[0], done_s[0], opa_s[0], opb_s[0], sum_s[0], max_s[0], err_s[0], pair_s[0]);
      end
      checks++;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      do_sweep(0, -1, -1, cyc);
      if (cyc !== N + 3 || sum_s[0] !== 16'(exp_sum) || max_s[0] !== 8'(exp_max) ||
          err_s[0] !== 9'(exp_err) || pair_s[0] !== 9'd256) begin
         fails++;
         $display("FAIL after_reset: cyc=%0d sum=%0d max=%0d err=%0d pair=%0d need %0d %0d %0d %0d 256",
                  cyc, sum_s[0], max_s[0], err_s[0], pair_s[0], N + 3, exp_sum, exp_max, exp_err);
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      int cyc;
      if (done_s[0] !== 1'b1) begin fails++; $display("FAIL b2b_precond: done=%b need 1", done_s[0]); end
      checks++;
      mode = 2;
      for (int rep = 0; rep < 2; rep++) begin
         do_sweep(0, -1, -1, cyc);
         if (cyc !== N + 3 || sum_s[0] !== 16'd14400 || max_s[0] !== 8'd225 || err_s[0] !== 9'd225 || pair_s[0] !== 9'd256) begin
            fails++;
            $display("FAIL b2b_metrics[%0d]: cyc=%0d sum=%0d max=%0d err=%0d pair=%0d need %0d 14400 225 225 256",
                     rep, cyc, sum_s[0], max_s[0], err_s[0], pair_s[0], N + 3);
         end
         checks++;
      end
   endtask

   initial begin
      rst  = 1'b1;
      mode = 0;
      for (int k = 0; k < 3; k++) start_s[k] = 1'b0;
      test_reset();
      test_exact_lat3();
      test_lsb_lat0();
      test_zero_lat2();
      test_random_error();
      test_start_while_busy();
      test_reset_mid_sweep();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
